prog_loader_harvard: RTL

- Upstream stage of the 8-bit Harvard micro: owns the instruction memory and drives the micro's 9-bit instruction input from the micro's instruction address.
- Loads the program from a byte stream (UART receiver / host FIFO, valid/ready handshake) and holds the micro in reset until a complete, well-formed image has been written.
- Allows reload at runtime without a board reset.

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/instr_ram.sv | 25 ++
 rtl/prog_loader_harvard.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the Harvard program loader.
// State encoding is common to the default and checksum builds.
package prog_loader_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 9;

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        CSUM  = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    // HI-byte bits above the instruction width must be zero.
    function automatic logic [BYTE_W-1:0] rsv_mask(input int instr_w);
        logic [15:0] wide;
        wide = 16'h00ff << (instr_w - BYTE_W);
        return wide[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// A same-cycle read of the address being written returns the old word.
module instr_ram #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_harvard.sv
// Program loader for the 8-bit Harvard micro: streams an image into instr_ram
// and holds the micro in reset until it is complete. Optional image checksum
// is enabled by defining PROG_LOADER_CHECKSUM_EN.
//
// state | meaning
// LEN   | waiting for the word-count byte
// LO    | waiting for the low byte of the next word
// HI    | waiting for the high byte; writes the word
// CSUM  | waiting for the checksum byte (checksum build only)
// RUN   | image valid, micro released from reset
// ERROR | malformed image, micro held in reset until i_start
module prog_loader_harvard
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_direccion_instruccion,
    output logic [INSTR_W-1:0] o_instruccion,
    output logic               o_cpu_rst_n,
    output logic               o_load_done,
    output logic               o_error
);

    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [BYTE_W-1:0] RSV_MASK  = rsv_mask(INSTR_W);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [BYTE_W-1:0]   lo_reg, lo_nxt;
    logic                run_q;
    logic                accept;
    logic                we;
    logic [INSTR_W-1:0]  wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   sum, sum_nxt, sum_chk;
`endif

    assign accept       = i_byte_valid && o_byte_ready;
    assign o_byte_ready = (state == LEN) || (state == LO) || (state == HI) || (state == CSUM);
    assign wdata        = {i_byte[INSTR_W-BYTE_W-1:0], lo_reg};
`ifdef PROG_LOADER_CHECKSUM_EN
    assign sum_chk      = sum + i_byte;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LEN;
            addr   <= '0;
            count  <= '0;
            lo_reg <= '0;
            run_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum    <= '0;
`endif
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            count  <= count_nxt;
            lo_reg <= lo_nxt;
            // Rises one edge after RUN is entered, drops on the i_start edge.
            run_q  <= (state == RUN) && !i_start;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum    <= sum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        count_nxt = count;
        lo_nxt    = lo_reg;
        we        = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_nxt   = sum;
`endif
        if (i_start) begin
            state_nxt = LEN;
            addr_nxt  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_nxt   = '0;
`endif
        end else begin
            case (state)
                LEN: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_nxt = accept ? i_byte : '0;
`endif
                    if (accept) begin
                        count_nxt = (i_byte == '0) ? DEPTH_CNT : CNT_W'(i_byte);
                        addr_nxt  = '0;
                        state_nxt = LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        lo_nxt    = i_byte;
                        state_nxt = HI;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_nxt   = sum_chk;
`endif
                    end
                end
                HI: begin
                    if (accept) begin
                        if ((i_byte & RSV_MASK) != '0) begin
                            state_nxt = ERROR;
                        end else begin
                            we        = 1'b1;
                            addr_nxt  = addr + ADDR_W'(1);
                            count_nxt = count - CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                            sum_nxt   = sum_chk;
                            state_nxt = (count == CNT_W'(1)) ? CSUM : LO;
`else
                            state_nxt = (count == CNT_W'(1)) ? RUN : LO;
`endif
                        end
                    end
                end
                CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (accept) begin
                        state_nxt = (sum_chk == '0) ? RUN : ERROR;
                    end
`else
                    state_nxt = LEN;
`endif
                end
                RUN:     state_nxt = RUN;
                ERROR:   state_nxt = ERROR;
                default: state_nxt = LEN;
            endcase
        end
    end

    assign o_cpu_rst_n = run_q;
    assign o_load_done = run_q;
    assign o_error     = (state == ERROR);

    instr_ram #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_instr_ram (
        .clk   (clk),
        .we    (we),
        .waddr (addr),
        .wdata (wdata),
        .raddr (i_direccion_instruccion),
        .rdata (o_instruccion)
    );

endmodule
